vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Parametrised VGA/SVGA timing generator: the next generation of the fixed 640x480 sync block.
- Timing, clock-division ratio and sync polarity are all parameters.
- Adds a run/hold enable, line/frame strobes and a frame counter.
- Sits between the system clock and the pixel/graphics generators; everything downstream qualifies on p_tick.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 2, clk cycles per pixel; legal range 1..16
- HS_POL, 0, hsync asserted level (0 = active-low)
- VS_POL, 0, vsync asserted level (0 = active-low)
- CNT_W, 11, width of pixel_x/pixel_y; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  run enable; low freezes all timing state
- hsync  out  1  horizontal sync, polarity HS_POL, registered
- vsync  out  1  vertical sync, polarity VS_POL, registered
- video_on  out  1  high while pixel_x<H_ACTIVE and pixel_y<V_ACTIVE
- p_tick  out  1  one-clk pixel enable strobe
- pixel_x  out  CNT_W  horizontal counter
- pixel_y  out  CNT_W  vertical counter
- line_start  out  1  one-clk strobe on the last pixel of each line
- frame_start  out  1  one-clk strobe on the last pixel of each frame
- frame_cnt  out  8  frame counter, wraps 255->0

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
- Line order: active, front porch, sync, back porch. The same order applies vertically.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 while en=1.
  - p_tick=1 exactly when en=1 and div_cnt==CLK_DIV-1.
  - CLK_DIV=1 gives p_tick=en.
- Horizontal counter: on p_tick, pixel_x goes to 0 if it equals H_TOTAL-1, otherwise increments. It holds otherwise.
- Vertical counter: on p_tick with pixel_x==H_TOTAL-1, pixel_y goes to 0 if it equals V_TOTAL-1, otherwise increments.
- Sync outputs:
  - hsync is asserted for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]. Default range is 656..751.
  - vsync is asserted for y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]. Default range is 490..491.
  - Both are registered from the next-state counter values, so they change in the same clk edge as pixel_x/pixel_y. No one-cycle skew.
- video_on is decoded combinationally from the counter registers. It is glitch-free because the counters are registered.
- line_start = p_tick & (pixel_x==H_TOTAL-1).
- frame_start = line_start & (pixel_y==V_TOTAL-1). frame_cnt increments on the same edge that pixel_x/pixel_y wrap to 0,0.
- en=0 freezes:
  - div_cnt, both counters, syncs and frame_cnt hold.
  - p_tick, line_start and frame_start are 0.
  - On re-enable, counting resumes from the held div_cnt value.
- Reset (asynchronous, any time including mid-frame):
  - div_cnt, pixel_x, pixel_y and frame_cnt go to 0.
  - hsync=~HS_POL, vsync=~VS_POL (inactive).
  - p_tick, line_start and frame_start are 0.
  - video_on=1, since (0,0) is in the active area.
  - First p_tick occurs CLK_DIV clk cycles after reset deasserts, given en=1.
- Simultaneous events: a line wrap and a frame wrap on the same tick update x, y and frame_cnt in one edge.
- Illegal parameters (any width 0, CLK_DIV out of range, totals not fitting CNT_W) are rejected by elaboration-time checks.

Decomposition:
- Package vga_timing_pkg holds:
  - the default 640x480@60 constants, plus an 800x600 set for later use;
  - the derived H_TOTAL/V_TOTAL functions;
  - a clog2 helper for CNT_W checks.
- One sub-module, pixel_tick_div: the CLK_DIV divider with en, exposing only p_tick.
- Counters, sync decode and frame counter stay in vga_timing_gen.

Test Plan:
- Reset hold then release, defaults, en=1 -> all counters 0, hsync=vsync=1, video_on=1; first p_tick on 2nd clk; p_tick then pulses every 2 clks.
- Run one line -> hsync low exactly while pixel_x in 656..751 (96 ticks); line_start pulses once at x=799; x wraps 799->0 and y goes 0->1.
- Run one full frame -> vsync low for y=490..491; frame_start once at (799,524); counters return to (0,0); frame_cnt 0->1; exactly 420000 p_ticks per frame.
- Small config (H 4/1/2/1, V 3/1/1/1, CLK_DIV=1, HS_POL=VS_POL=1) -> H_TOTAL=8, V_TOTAL=6; hsync high at x=5..6 and vsync high at y=4; frame_cnt wraps 255->0 after 256 frames (12288 clks).
- Drop en at x=300 for 10 clks -> x, y, syncs and div_cnt frozen; no strobes; resumes at x=300 with the original p_tick spacing.
- Assert reset mid-frame at (700,491) -> immediate asynchronous return to reset values, with no strobe emitted.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared timing constants and helpers for the VGA/SVGA timing generator.
package vga_timing_pkg;

    // 640x480@60 (25.175 MHz pixel clock), negative syncs
    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FP     = 16;
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BP     = 48;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FP     = 10;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BP     = 33;

    // 800x600@60 (40 MHz pixel clock), positive syncs
    localparam int SVGA800_H_ACTIVE = 800;
    localparam int SVGA800_H_FP     = 40;
    localparam int SVGA800_H_SYNC   = 128;
    localparam int SVGA800_H_BP     = 88;
    localparam int SVGA800_V_ACTIVE = 600;
    localparam int SVGA800_V_FP     = 1;
    localparam int SVGA800_V_SYNC   = 4;
    localparam int SVGA800_V_BP     = 23;

    // Upper bound of the pixel clock divider
    localparam int CLK_DIV_MAX = 16;

    // Total pixels per line, blanking included
    function automatic int calc_h_total(int active, int fp, int sync, int bp);
        return active + fp + sync + bp;
    endfunction

    // Total lines per frame, blanking included
    function automatic int calc_v_total(int active, int fp, int sync, int bp);
        return active + fp + sync + bp;
    endfunction

    // Bits needed to represent values 0..value-1
    function automatic int clog2(int value);
        int bits;
        bits = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            bits = bits + 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Divides the system clock down to a one-clk pixel enable strobe.
module pixel_tick_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic p_tick
);

    // 4 bits cover the full 1..16 divide range
    localparam int               DIV_W    = 4;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_reg;
    logic [DIV_W-1:0] div_cnt_next;

    // Advance the phase only while running; a low en parks it where it is
    always_comb begin
        div_cnt_next = div_cnt_reg;
        if (en) begin
            if (div_cnt_reg == DIV_LAST) begin
                div_cnt_next = '0;
            end else begin
                div_cnt_next = div_cnt_reg + DIV_W'(1);
            end
        end
    end

    // Phase register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_reg <= '0;
        end else begin
            div_cnt_reg <= div_cnt_next;
        end
    end

    // Reset gating keeps the strobe quiet while reset is held, even at CLK_DIV=1
    assign p_tick = en & ~reset & (div_cnt_reg == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/SVGA timing generator: pixel/line counters, registered
// syncs, video_on decode, line/frame strobes and a free-running frame counter.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = VGA640_H_ACTIVE,
    parameter int H_FP     = VGA640_H_FP,
    parameter int H_SYNC   = VGA640_H_SYNC,
    parameter int H_BP     = VGA640_H_BP,
    parameter int V_ACTIVE = VGA640_V_ACTIVE,
    parameter int V_FP     = VGA640_V_FP,
    parameter int V_SYNC   = VGA640_V_SYNC,
    parameter int V_BP     = VGA640_V_BP,
    parameter int CLK_DIV  = 2,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CNT_W    = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic             p_tick,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             line_start,
    output logic             frame_start,
    output logic [7:0]       frame_cnt
);

    localparam int H_TOTAL = calc_h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = calc_v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] X_ACTIVE = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] Y_ACTIVE = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic HS_ON = HS_POL;
    localparam logic VS_ON = VS_POL;

    localparam int NUM_SEGMENTS = 8;

    // Indexed view of the eight porch/sync/active widths for the checks below
    function automatic int segment_width(int idx);
        case (idx)
            0:       return H_ACTIVE;
            1:       return H_FP;
            2:       return H_SYNC;
            3:       return H_BP;
            4:       return V_ACTIVE;
            5:       return V_FP;
            6:       return V_SYNC;
            7:       return V_BP;
            default: return 1;
        endcase
    endfunction

    // Elaboration-time rejection of unusable parameter sets
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SEGMENTS; gi++) begin : g_width_chk
            if (segment_width(gi) < 1) begin : g_zero_width
                $error("vga_timing_gen: timing segment %0d has zero width", gi);
            end
        end
        if (CLK_DIV < 1 || CLK_DIV > CLK_DIV_MAX) begin : g_bad_div
            $error("vga_timing_gen: CLK_DIV %0d outside 1..%0d", CLK_DIV, CLK_DIV_MAX);
        end
        if (clog2(H_TOTAL) > CNT_W || clog2(V_TOTAL) > CNT_W) begin : g_bad_cnt_w
            $error("vga_timing_gen: CNT_W %0d too narrow for %0dx%0d totals",
                   CNT_W, H_TOTAL, V_TOTAL);
        end
    endgenerate

    logic [CNT_W-1:0] x_reg;
    logic [CNT_W-1:0] x_next;
    logic [CNT_W-1:0] y_reg;
    logic [CNT_W-1:0] y_next;
    logic             hsync_reg;
    logic             hsync_next;
    logic             vsync_reg;
    logic             vsync_next;
    logic [7:0]       frame_cnt_reg;
    logic [7:0]       frame_cnt_next;
    logic             x_wrap;
    logic             y_wrap;

    pixel_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_div (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .p_tick (p_tick)
    );

    assign x_wrap      = (x_reg == X_LAST);
    assign y_wrap      = (y_reg == Y_LAST);
    assign line_start  = p_tick & x_wrap;
    assign frame_start = line_start & y_wrap;

    // Next counter state: x steps per tick, y per line, frame_cnt per frame,
    // so a combined line+frame wrap lands in a single edge
    always_comb begin
        x_next         = x_reg;
        y_next         = y_reg;
        frame_cnt_next = frame_cnt_reg;
        if (p_tick) begin
            x_next = x_wrap ? '0 : x_reg + CNT_ONE;
        end
        if (line_start) begin
            y_next = y_wrap ? '0 : y_reg + CNT_ONE;
        end
        if (frame_start) begin
            frame_cnt_next = frame_cnt_reg + 8'd1;
        end
    end

    // Syncs decoded from the next-state counters so they line up with pixel_x/pixel_y
    always_comb begin
        hsync_next = ((x_next >= HS_START) && (x_next <= HS_END)) ? HS_ON : ~HS_ON;
        vsync_next = ((y_next >= VS_START) && (y_next <= VS_END)) ? VS_ON : ~VS_ON;
    end

    // Timing state registers; with en low every next value equals the current one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_reg         <= '0;
            y_reg         <= '0;
            hsync_reg     <= ~HS_ON;
            vsync_reg     <= ~VS_ON;
            frame_cnt_reg <= '0;
        end else begin
            x_reg         <= x_next;
            y_reg         <= y_next;
            hsync_reg     <= hsync_next;
            vsync_reg     <= vsync_next;
            frame_cnt_reg <= frame_cnt_next;
        end
    end

    assign hsync     = hsync_reg;
    assign vsync     = vsync_reg;
    assign pixel_x   = x_reg;
    assign pixel_y   = y_reg;
    assign frame_cnt = frame_cnt_reg;
    assign video_on  = (x_reg < X_ACTIVE) && (y_reg < Y_ACTIVE);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a tiny 8x6 instance
// driven with random enables, checked each cycle against a tick-count model.
module tb_vga_timing_gen;

    typedef struct packed {
        logic        hsync;
        logic        vsync;
        logic        video_on;
        logic        p_tick;
        logic        line_start;
        logic        frame_start;
        logic [10:0] x;
        logic [10:0] y;
        logic [7:0]  fc;
    } obs_t;

    typedef struct {
        int ha, hfp, hs, hbp, va, vfp, vs, vbp, div;
        bit hp, vp;
    } cfg_t;

    localparam int MAX_CYC  = 40000;
    localparam int B_FRAMES = 256 * 48;

    logic        clk = 1'b0;
    logic        rst_a, rst_b, en_a, en_b;
    logic        hs_a, vs_a, von_a, pt_a, ls_a, fs_a;
    logic        hs_b, vs_b, von_b, pt_b, ls_b, fs_b;
    logic [10:0] px_a, py_a;
    logic [3:0]  px_b, py_b;
    logic [7:0]  fc_a, fc_b;
    obs_t        obs_a, obs_b;

    obs_t q_a[$];
    obs_t q_b[$];
    cfg_t cfg [2];
    int   t [2];
    int   n [2];

    int checks = 0;
    int failures = 0;
    int hs_ticks = 0;
    int fs_b_count = 0;

    always #5 clk = ~clk;

    vga_timing_gen dut_a (
        .clk(clk), .reset(rst_a), .en(en_a), .hsync(hs_a), .vsync(vs_a),
        .video_on(von_a), .p_tick(pt_a), .pixel_x(px_a), .pixel_y(py_a),
        .line_start(ls_a), .frame_start(fs_a), .frame_cnt(fc_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(1), .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(4)
    ) dut_b (
        .clk(clk), .reset(rst_b), .en(en_b), .hsync(hs_b), .vsync(vs_b),
        .video_on(von_b), .p_tick(pt_b), .pixel_x(px_b), .pixel_y(py_b),
        .line_start(ls_b), .frame_start(fs_b), .frame_cnt(fc_b)
    );

    assign obs_a = {hs_a, vs_a, von_a, pt_a, ls_a, fs_a, px_a, py_a, fc_a};
    assign obs_b = {hs_b, vs_b, von_b, pt_b, ls_b, fs_b, 11'(px_b), 11'(py_b), fc_b};

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, req);
        end
    endtask

    task automatic check_obs(input string name, input obs_t act, input obs_t req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s at %0t: actual hs=%b vs=%b von=%b pt=%b ls=%b fs=%b x=%0d y=%0d fc=%0d required hs=%b vs=%b von=%b pt=%b ls=%b fs=%b x=%0d y=%0d fc=%0d",
                     name, $time, act.hsync, act.vsync, act.video_on, act.p_tick,
                     act.line_start, act.frame_start, act.x, act.y, act.fc,
                     req.hsync, req.vsync, req.video_on, req.p_tick,
                     req.line_start, req.frame_start, req.x, req.y, req.fc);
        end
    endtask

    // Reference: position is just the number of pixel ticks since reset,
    // the tick itself falls on every CLK_DIV-th enabled cycle.
    function automatic obs_t expect_obs(input cfg_t c, input int ticks, input int en_cycles,
                                        input bit en, input bit rst);
        obs_t o;
        int ht, vt, x, y;
        ht = c.ha + c.hfp + c.hs + c.hbp;
        vt = c.va + c.vfp + c.vs + c.vbp;
        x  = ticks % ht;
        y  = (ticks / ht) % vt;
        o.p_tick      = en && !rst && ((en_cycles % c.div) == c.div - 1);
        o.x           = 11'(x);
        o.y           = 11'(y);
        o.fc          = 8'((ticks / (ht * vt)) % 256);
        o.hsync       = (x >= c.ha + c.hfp && x < c.ha + c.hfp + c.hs) ? c.hp : !c.hp;
        o.vsync       = (y >= c.va + c.vfp && y < c.va + c.vfp + c.vs) ? c.vp : !c.vp;
        o.video_on    = (x < c.ha) && (y < c.va);
        o.line_start  = o.p_tick && (x == ht - 1);
        o.frame_start = o.line_start && (y == vt - 1);
        return o;
    endfunction

    // Push this cycle's expectation for one instance, then advance its model
    task automatic model_step(input int k, input bit en, input bit rst);
        obs_t e;
        if (rst) begin
            t[k] = 0;
            n[k] = 0;
        end
        e = expect_obs(cfg[k], t[k], n[k], en, rst);
        if (k == 0) q_a.push_back(e);
        else        q_b.push_back(e);
        if (!rst && en) begin
            if (e.p_tick) t[k] = t[k] + 1;
            n[k] = n[k] + 1;
        end
    endtask

    // Stimulus: reset, run to x=300, freeze, random enables, mid-frame reset
    initial begin
        int  cyc, phase, hold;
        bit  done, reset_chk;
        cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0, 1'b0};
        cfg[1] = '{4, 1, 2, 1, 3, 1, 1, 1, 1, 1'b1, 1'b1};
        t[0] = 0; t[1] = 0; n[0] = 0; n[1] = 0;
        rst_a = 1'b1; rst_b = 1'b1; en_a = 1'b1; en_b = 1'b1;
        cyc = 0; phase = 0; hold = 0; done = 1'b0;
        while (!done && cyc < MAX_CYC) begin
            @(negedge clk);
            reset_chk = 1'b0;
            rst_a = 1'b0;
            rst_b = 1'b0;
            if (cyc < 3) begin
                rst_a = 1'b1; rst_b = 1'b1; en_a = 1'b1; en_b = 1'b1;
            end else begin
                case (phase)
                    0: begin
                        en_a = 1'b1;
                        if (t[0] == 2 * 800 + 300) begin
                            $display("phase: freeze dut_a at x=%0d y=%0d", px_a, py_a);
                            phase = 1; hold = 0; en_a = 1'b0;
                        end
                    end
                    1: begin
                        en_a = 1'b0;
                        hold++;
                        if (hold == 10) begin
                            phase = 2; hold = 0; en_a = 1'b1;
                        end
                    end
                    2: begin
                        en_a = ($urandom_range(3, 0) != 0);
                        hold++;
                        if (hold == 2000) phase = 3;
                    end
                    3: begin
                        en_a = 1'b1;
                        if (t[0] % 800 == 700 && t[0] >= 800) begin
                            check_int("pre_reset_x", int'(px_a), 700);
                            $display("phase: async reset dut_a at x=%0d y=%0d", px_a, py_a);
                            rst_a = 1'b1; reset_chk = 1'b1; phase = 4;
                        end
                    end
                    4: begin
                        rst_a = 1'b1; phase = 5;
                    end
                    default: begin
                        en_a = ($urandom_range(3, 0) != 0);
                    end
                endcase
                en_b = (t[1] < B_FRAMES) ? ($urandom_range(3, 0) != 0) : 1'b0;
                done = (phase == 5) && (t[1] >= B_FRAMES);
            end
            model_step(0, en_a, rst_a);
            model_step(1, en_b, rst_b);
            if (cyc == 1 || cyc == 3 || cyc == 4 || reset_chk || (phase == 1 && hold == 9)) begin
                #1;
                if (cyc == 1) begin
                    check_int("reset_hsync_a", int'(hs_a), 1);
                    check_int("reset_vsync_a", int'(vs_a), 1);
                    check_int("reset_video_on_a", int'(von_a), 1);
                    check_int("reset_ptick_b", int'(pt_b), 0);
                    check_int("reset_hsync_b", int'(hs_b), 0);
                end
                if (cyc == 3) check_int("first_ptick_early", int'(pt_a), 0);
                if (cyc == 4) check_int("first_ptick_2nd_clk", int'(pt_a), 1);
                if (reset_chk) begin
                    check_int("async_reset_x", int'(px_a), 0);
                    check_int("async_reset_y", int'(py_a), 0);
                    check_int("async_reset_strobes", int'({pt_a, ls_a, fs_a}), 0);
                    check_int("async_reset_syncs", int'({hs_a, vs_a, von_a}), 7);
                end
                if (phase == 1 && hold == 9) begin
                    check_int("freeze_x", int'(px_a), 300);
                    check_int("freeze_ptick", int'(pt_a), 0);
                end
            end
            cyc++;
        end
        check_int("stimulus_done", int'(done), 1);
        #2;
        check_int("b_frame_starts", fs_b_count, 256);
        check_int("b_frame_cnt_wrapped", int'(fc_b), 0);
        check_int("b_home_xy", int'({px_b, py_b}), 0);
        check_int("queue_a_drained", q_a.size(), 0);
        check_int("queue_b_drained", q_b.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Monitor: pops one expectation per instance per cycle and compares
    initial begin
        obs_t e;
        forever begin
            @(negedge clk);
            #1;
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                check_obs("dut_a_cycle", obs_a, e);
            end
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                check_obs("dut_b_cycle", obs_b, e);
            end
            if (rst_a) begin
                hs_ticks = 0;
            end else begin
                if (pt_a && !hs_a) hs_ticks++;
                if (ls_a) begin
                    $display("line a: y=%0d hsync_ticks=%0d", py_a, hs_ticks);
                    check_int("a_hsync_width", hs_ticks, 96);
                    hs_ticks = 0;
                end
            end
            if (!rst_b && fs_b) begin
                fs_b_count++;
                if (fc_b == 8'd255) $display("frame b: frame_cnt wraps after %0d frames", fs_b_count);
            end
        end
    end

endmodule
